// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for multi_pulse_gen.
// Covers the channel FSM state encoding, the config register select encoding and the
// default counter width.
package pulse_gen_pkg;

    // Default width of every timing counter and config register
    localparam int unsigned CntWDefault = 32;

    // Width of the channel select field on the config port
    localparam int unsigned CfgChW = 4;

    // Per-channel sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StActive = 2'd2,
        StGap    = 2'd3
    } chan_state_e;

    // Config register select encodings
    typedef enum logic [1:0] {
        CfgDelay = 2'd0,
        CfgWidth = 2'd1,
        CfgGap   = 2'd2,
        CfgCount = 2'd3
    } cfg_sel_e;

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse channel: IDLE -> DELAY -> ACTIVE -> GAP -> ACTIVE ... -> IDLE.
// All outputs are registered.
// The config is captured into a shadow set on trigger, so later config writes do not
// disturb a running sequence.
// Optional build macro PULSEGEN_RETRIG_EN: a trigger while busy reloads the shadow set and
// restarts the sequence at DELAY. The cut sequence produces no done pulse.
module pulse_gen_chan
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             trig_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_gap_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic             default_level_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
);

`ifdef PULSEGEN_RETRIG_EN
    localparam bit RetrigEn = 1'b1;
`else
    localparam bit RetrigEn = 1'b0;
`endif

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             inf_q, inf_d;
    logic [CNT_W-1:0] sh_width_q, sh_width_d;
    logic [CNT_W-1:0] sh_gap_q, sh_gap_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             out_vld_q;

    logic             start_req;
    logic             last_tick;

    // Down-count that sticks at zero instead of wrapping
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        sat_dec = (v == '0) ? v : v - CNT_W'(1);
    endfunction

    // Trigger is accepted only with a non-zero width, and only from IDLE unless
    // retriggering is enabled
    assign start_req = trig_i && (cfg_width_i != '0) && ((state_q == StIdle) || RetrigEn);

    // Current phase ends this cycle; a zero GAP still spends one cycle in GAP
    assign last_tick = (timer_q <= CNT_W'(1));

    // Next-state, counter and shadow-set update
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pulses_d   = pulses_q;
        inf_d      = inf_q;
        sh_width_d = sh_width_q;
        sh_gap_d   = sh_gap_q;
        done_d     = 1'b0;

        if (abort_i) begin
            // Abort beats a coincident trigger and never signals done
            state_d  = StIdle;
            timer_d  = '0;
            pulses_d = '0;
        end else if (start_req) begin
            sh_width_d = cfg_width_i;
            sh_gap_d   = cfg_gap_i;
            pulses_d   = cfg_count_i;
            inf_d      = (cfg_count_i == '0);
            if (cfg_delay_i == '0) begin
                state_d = StActive;
                timer_d = cfg_width_i;
            end else begin
                state_d = StDelay;
                timer_d = cfg_delay_i;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_d = '0;
                end
                StDelay: begin
                    if (last_tick) begin
                        state_d = StActive;
                        timer_d = sh_width_q;
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
                StActive: begin
                    if (last_tick) begin
                        if (!inf_q && (pulses_q <= CNT_W'(1))) begin
                            // Last pulse: straight to IDLE, no trailing gap
                            state_d  = StIdle;
                            done_d   = 1'b1;
                            timer_d  = '0;
                            pulses_d = '0;
                        end else begin
                            state_d = StGap;
                            timer_d = sh_gap_q;
                            if (!inf_q) begin
                                pulses_d = sat_dec(pulses_q);
                            end
                        end
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
                StGap: begin
                    if (last_tick) begin
                        state_d = StActive;
                        timer_d = sh_width_q;
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Registered outputs follow the next state; level changes land one cycle later
    always_comb begin
        pulse_d = (state_d == StActive) ^ default_level_i;
        busy_d  = (state_d != StIdle);
    end

    // Channel state, counters, shadow set and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            pulses_q   <= '0;
            inf_q      <= 1'b0;
            sh_width_q <= '0;
            sh_gap_q   <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pulses_q   <= pulses_d;
            inf_q      <= inf_d;
            sh_width_q <= sh_width_d;
            sh_gap_q   <= sh_gap_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_vld_q  <= 1'b1;
        end
    end

    // The idle level cannot be a reset value, so bypass the output flop until it has
    // been loaded once after reset
    assign pulse_o = (rst_ni && out_vld_q) ? pulse_q : default_level_i;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel programmable pulse generator.
// Holds the per-channel config registers and write decode. Each channel's sequencer lives
// in pulse_gen_chan.
// Optional build macro PULSEGEN_RETRIG_EN enables restart-on-retrigger in every channel.
module multi_pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input  logic              io_clk,
    input  logic              io_rst_n,
    input  logic [NUM_CH-1:0] io_trig,
    input  logic [NUM_CH-1:0] io_abort,
    input  logic              io_cfgWe,
    input  logic [3:0]        io_cfgCh,
    input  logic [1:0]        io_cfgSel,
    input  logic [CNT_W-1:0]  io_cfgData,
    input  logic [NUM_CH-1:0] io_defaultLevel,
    output logic [NUM_CH-1:0] io_pulseOut,
    output logic [NUM_CH-1:0] io_busy,
    output logic [NUM_CH-1:0] io_done
);

    logic [NUM_CH-1:0][CNT_W-1:0] cfg_delay_q, cfg_delay_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cfg_width_q, cfg_width_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cfg_gap_q, cfg_gap_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cfg_count_q, cfg_count_d;
    cfg_sel_e                     cfg_sel;

    assign cfg_sel = cfg_sel_e'(io_cfgSel);

    // Config write decode; a channel index at or above NUM_CH matches nothing
    always_comb begin
        cfg_delay_d = cfg_delay_q;
        cfg_width_d = cfg_width_q;
        cfg_gap_d   = cfg_gap_q;
        cfg_count_d = cfg_count_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (io_cfgWe && (io_cfgCh == CfgChW'(c))) begin
                unique case (cfg_sel)
                    CfgDelay: cfg_delay_d[c] = io_cfgData;
                    CfgWidth: cfg_width_d[c] = io_cfgData;
                    CfgGap:   cfg_gap_d[c]   = io_cfgData;
                    CfgCount: cfg_count_d[c] = io_cfgData;
                    default:  ;
                endcase
            end
        end
    end

    // Config register file
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            cfg_delay_q <= '0;
            cfg_width_q <= '0;
            cfg_gap_q   <= '0;
            cfg_count_q <= '0;
        end else begin
            cfg_delay_q <= cfg_delay_d;
            cfg_width_q <= cfg_width_d;
            cfg_gap_q   <= cfg_gap_d;
            cfg_count_q <= cfg_count_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_chan
        pulse_gen_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i           (io_clk),
            .rst_ni          (io_rst_n),
            .trig_i          (io_trig[g]),
            .abort_i         (io_abort[g]),
            .cfg_delay_i     (cfg_delay_q[g]),
            .cfg_width_i     (cfg_width_q[g]),
            .cfg_gap_i       (cfg_gap_q[g]),
            .cfg_count_i     (cfg_count_q[g]),
            .default_level_i (io_defaultLevel[g]),
            .pulse_o         (io_pulseOut[g]),
            .busy_o          (io_busy[g]),
            .done_o          (io_done[g])
        );
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed self-checking bench for multi_pulse_gen.
// Bit i of each captured vector is the value observed in cycle T+1+i after a trigger in
// cycle T.
module tb_multi_pulse_gen;

    localparam int unsigned NumCh = 4;
    localparam int unsigned CntW  = 16;

    logic             io_clk = 1'b0;
    logic             io_rst_n = 1'b0;
    logic [NumCh-1:0] io_trig = '0;
    logic [NumCh-1:0] io_abort = '0;
    logic             io_cfgWe = 1'b0;
    logic [3:0]       io_cfgCh = '0;
    logic [1:0]       io_cfgSel = '0;
    logic [CntW-1:0]  io_cfgData = '0;
    logic [NumCh-1:0] io_defaultLevel = '0;
    logic [NumCh-1:0] io_pulseOut;
    logic [NumCh-1:0] io_busy;
    logic [NumCh-1:0] io_done;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] p, d, b;

    multi_pulse_gen #(
        .NUM_CH (NumCh),
        .CNT_W  (CntW)
    ) dut (
        .io_clk          (io_clk),
        .io_rst_n        (io_rst_n),
        .io_trig         (io_trig),
        .io_abort        (io_abort),
        .io_cfgWe        (io_cfgWe),
        .io_cfgCh        (io_cfgCh),
        .io_cfgSel       (io_cfgSel),
        .io_cfgData      (io_cfgData),
        .io_defaultLevel (io_defaultLevel),
        .io_pulseOut     (io_pulseOut),
        .io_busy         (io_busy),
        .io_done         (io_done)
    );

    initial forever #5 io_clk = ~io_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [1:0] sel,
                             input logic [CntW-1:0] data);
        io_cfgWe   = 1'b1;
        io_cfgCh   = ch;
        io_cfgSel  = sel;
        io_cfgData = data;
        tick();
        io_cfgWe = 1'b0;
    endtask

    // Drive trig_m (plus any preset abort/config write) in the current cycle, then capture
    // channel ch for n cycles
    task automatic run(input logic [NumCh-1:0] trig_m, input int ch, input int n,
                       output logic [31:0] po, output logic [31:0] dn, output logic [31:0] bs);
        po = '0;
        dn = '0;
        bs = '0;
        io_trig = trig_m;
        for (int i = 0; i < n; i++) begin
            tick();
            io_trig  = '0;
            io_abort = '0;
            io_cfgWe = 1'b0;
            po[i] = io_pulseOut[ch];
            dn[i] = io_done[ch];
            bs[i] = io_busy[ch];
        end
    endtask

    initial begin
        // Reset state
        io_defaultLevel = 4'b0101;
        repeat (3) tick();
        check_eq("rst_pulse", 32'(io_pulseOut), 32'h5);
        check_eq("rst_busy", 32'(io_busy), 32'h0);
        check_eq("rst_done", 32'(io_done), 32'h0);
        io_rst_n = 1'b1;
        tick();
        tick();
        check_eq("lvl_after_rst", 32'(io_pulseOut), 32'h5);
        io_defaultLevel = 4'b0011;
        check_eq("lvl_hold", 32'(io_pulseOut), 32'h5);
        tick();
        check_eq("lvl_next", 32'(io_pulseOut), 32'h3);
        io_defaultLevel = 4'b0000;
        tick();

        // ch0 D=3 W=2 COUNT=1
        cfg_write(4'd0, 2'd0, 16'd3);
        cfg_write(4'd0, 2'd1, 16'd2);
        cfg_write(4'd0, 2'd3, 16'd1);
        run(4'b0001, 0, 8, p, d, b);
        check_eq("ch0_pulse", p, 32'h18);
        check_eq("ch0_done", d, 32'h20);
        check_eq("ch0_busy", b, 32'h1F);

        // ch1 D=0 W=1 GAP=2 COUNT=3
        cfg_write(4'd1, 2'd1, 16'd1);
        cfg_write(4'd1, 2'd2, 16'd2);
        cfg_write(4'd1, 2'd3, 16'd3);
        run(4'b0010, 1, 10, p, d, b);
        check_eq("ch1_pulse", p, 32'h049);
        check_eq("ch1_done", d, 32'h080);
        check_eq("ch1_busy", b, 32'h07F);

        // ch2 continuous W=4 GAP=4, then abort mid-ACTIVE
        cfg_write(4'd2, 2'd1, 16'd4);
        cfg_write(4'd2, 2'd2, 16'd4);
        cfg_write(4'd2, 2'd3, 16'd0);
        run(4'b0100, 2, 16, p, d, b);
        check_eq("ch2_pulse", p, 32'h0F0F);
        check_eq("ch2_done", d, 32'h0);
        check_eq("ch2_busy", b, 32'hFFFF);
        tick();
        tick();
        check_eq("ch2_mid_active", 32'(io_pulseOut[2]), 32'h1);
        io_abort = 4'b0100;
        tick();
        io_abort = '0;
        check_eq("ch2_abort_pulse", 32'(io_pulseOut[2]), 32'h0);
        check_eq("ch2_abort_busy", 32'(io_busy[2]), 32'h0);
        check_eq("ch2_abort_done", 32'(io_done[2]), 32'h0);
        run(4'b0000, 2, 4, p, d, b);
        check_eq("ch2_after_abort", p | d | b, 32'h0);

        // ch3 active-low: D=1 W=2 COUNT=1, idle level 1
        io_defaultLevel = 4'b1000;
        cfg_write(4'd3, 2'd0, 16'd1);
        cfg_write(4'd3, 2'd1, 16'd2);
        cfg_write(4'd3, 2'd3, 16'd1);
        run(4'b1000, 3, 6, p, d, b);
        check_eq("ch3_pulse", p, 32'h39);
        check_eq("ch3_done", d, 32'h08);
        check_eq("ch3_busy", b, 32'h07);
        io_defaultLevel = 4'b0000;
        tick();

        // Config write in the trigger cycle must not reach the shadow set
        cfg_write(4'd1, 2'd3, 16'd1);
        io_cfgWe   = 1'b1;
        io_cfgCh   = 4'd1;
        io_cfgSel  = 2'd1;
        io_cfgData = 16'd3;
        run(4'b0010, 1, 4, p, d, b);
        check_eq("shadow_pulse", p, 32'h1);
        check_eq("shadow_done", d, 32'h2);
        run(4'b0010, 1, 6, p, d, b);
        check_eq("newcfg_pulse", p, 32'h07);
        check_eq("newcfg_done", d, 32'h08);

        // ch0 D=2 W=3: rewrite WIDTH=1 in T+2, retrigger in T+3
        cfg_write(4'd0, 2'd0, 16'd2);
        cfg_write(4'd0, 2'd1, 16'd3);
        p = '0;
        d = '0;
        b = '0;
        io_trig = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            io_trig  = '0;
            io_cfgWe = 1'b0;
            p[i] = io_pulseOut[0];
            d[i] = io_done[0];
            b[i] = io_busy[0];
            if (i == 1) begin
                io_cfgWe   = 1'b1;
                io_cfgCh   = 4'd0;
                io_cfgSel  = 2'd1;
                io_cfgData = 16'd1;
            end
            if (i == 2) begin
                io_trig = 4'b0001;
            end
        end
`ifdef PULSEGEN_RETRIG_EN
        check_eq("retrig_pulse", p, 32'h024);
        check_eq("retrig_done", d, 32'h040);
        check_eq("retrig_busy", b, 32'h03F);
`else
        check_eq("retrig_pulse", p, 32'h01C);
        check_eq("retrig_done", d, 32'h020);
        check_eq("retrig_busy", b, 32'h01F);
`endif

        // Simultaneous trig+abort: abort wins
        io_abort = 4'b0001;
        run(4'b0001, 0, 6, p, d, b);
        check_eq("trig_abort", p | d | b, 32'h0);

        // Write to channel NUM_CH is dropped; ch0 keeps D=2 W=1 COUNT=1
        cfg_write(4'd4, 2'd1, 16'd5);
        run(4'b0001, 0, 6, p, d, b);
        check_eq("badch_pulse", p, 32'h04);
        check_eq("badch_done", d, 32'h08);
        check_eq("badch_busy", b, 32'h07);

        // WIDTH=0 trigger ignored
        cfg_write(4'd3, 2'd1, 16'd0);
        run(4'b1000, 3, 4, p, d, b);
        check_eq("w0_pulse", p, 32'h0);
        check_eq("w0_done", d, 32'h0);
        check_eq("w0_busy", b, 32'h0);

        // Reset in the middle of a ch2 pulse
        run(4'b0100, 2, 3, p, d, b);
        check_eq("pre_rst_pulse", p, 32'h7);
        io_defaultLevel = 4'b1010;
        io_rst_n = 1'b0;
        #1;
        check_eq("midrst_pulse", 32'(io_pulseOut), 32'hA);
        check_eq("midrst_busy", 32'(io_busy), 32'h0);
        check_eq("midrst_done", 32'(io_done), 32'h0);
        tick();
        check_eq("midrst_pulse_hold", 32'(io_pulseOut), 32'hA);
        io_rst_n = 1'b1;
        io_defaultLevel = 4'b0000;
        tick();
        // Config was cleared, so this trigger sees WIDTH=0
        run(4'b0001, 0, 6, p, d, b);
        check_eq("postrst_ch0", d | b, 32'h0);
        check_eq("postrst_busy_all", 32'(io_busy), 32'h0);
        check_eq("postrst_done_all", 32'(io_done), 32'h0);
        check_eq("postrst_pulse_all", 32'(io_pulseOut), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent pulse channels (1..16).
REQ-002 Parameter CNT_W, default 32, SHALL set the width of every timing counter and config register.
REQ-003 io_clk  in  1  SHALL be the single clock; every flop is rising-edge.
REQ-004 io_rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 io_trig  in  NUM_CH  SHALL be the per-channel start strobe, sampled each cycle.
REQ-006 io_abort  in  NUM_CH  SHALL be the per-channel stop strobe.
REQ-007 io_cfgWe  in  1  SHALL be the config write strobe.
REQ-008 io_cfgCh  in  4  SHALL be the target channel; writes with io_cfgCh >= NUM_CH are dropped.
REQ-009 io_cfgSel  in  2  SHALL select the register: 0=DELAY, 1=WIDTH, 2=GAP, 3=COUNT.
REQ-010 io_cfgData  in  CNT_W  SHALL be the write data.
REQ-011 io_defaultLevel  in  NUM_CH  SHALL be the per-channel idle level; the active level is its inverse.
REQ-012 io_pulseOut  out  NUM_CH  SHALL be the registered pulse outputs.
REQ-013 io_busy  out  NUM_CH  SHALL be high while a channel is not IDLE.
REQ-014 io_done  out  NUM_CH  SHALL pulse high for one cycle when a sequence completes normally.

Function
REQ-015 Each channel SHALL hold four config registers (DELAY, WIDTH, GAP, COUNT), each written in the cycle after io_cfgWe.
REQ-016 Each channel SHALL run the FSM IDLE -> DELAY -> ACTIVE -> GAP -> ACTIVE ... -> IDLE.
REQ-017 On io_trig in IDLE at cycle T, the channel SHALL copy all four config registers into a shadow set; a config write in the same cycle SHALL NOT reach that shadow set.
REQ-018 With shadow DELAY=D and WIDTH=W, io_pulseOut SHALL be at the active level in cycles T+1+D through T+D+W inclusive.
REQ-019 D=0 SHALL skip the DELAY state.
REQ-020 After each ACTIVE phase, if pulses remain, the output SHALL hold the idle level for exactly GAP cycles (GAP=0 means back-to-back with one idle cycle), then re-enter ACTIVE.
REQ-021 COUNT=N>0 SHALL emit exactly N pulses.
REQ-022 COUNT=0 SHALL emit pulses indefinitely until abort.
REQ-023 io_done SHALL assert in the first cycle after the last ACTIVE cycle, with no trailing GAP, and the channel SHALL be IDLE in that same cycle.
REQ-024 A trigger with shadow WIDTH=0 SHALL be ignored: the channel stays IDLE and io_done is not asserted.
REQ-025 io_trig while the channel is not IDLE SHALL be ignored (see REQ-031).
REQ-026 io_abort SHALL force the channel to IDLE and the output to the idle level in the next cycle, without io_done; if io_trig and io_abort coincide, abort SHALL win.
REQ-027 Counters SHALL count down with saturation at zero and never wrap; all lengths are unsigned CNT_W values.
REQ-028 A change of io_defaultLevel SHALL take effect on io_pulseOut in the next cycle.

Reset
REQ-029 While io_rst_n=0: all FSMs IDLE, all counters, config and shadow registers 0, io_busy=0, io_done=0.
REQ-030 While io_rst_n=0, io_pulseOut SHALL equal io_defaultLevel; reset mid-sequence SHALL discard the sequence with no io_done.

Configuration
REQ-031 With PULSEGEN_RETRIG_EN defined, io_trig in a non-IDLE state SHALL reload the shadow set and restart at DELAY, with no io_done for the cut sequence.
REQ-032 Without PULSEGEN_RETRIG_EN, REQ-025 applies unchanged.

Structure
REQ-033 Package pulse_gen_pkg SHALL hold the FSM state enum, the cfgSel encodings and the default CNT_W.
REQ-034 The per-channel FSM and counters SHALL be sub-module pulse_gen_chan, instantiated NUM_CH times by a generate loop; config decode SHALL live in the top level.

Verification
REQ-035 ch0 D=3, W=2, COUNT=1, defaultLevel=0; trig at cycle 10 -> pulseOut high in cycles 14-15; done in cycle 16; busy in cycles 11-15.
REQ-036 ch1 D=0, W=1, GAP=2, COUNT=3 -> pulses at T+1, T+4, T+7; done at T+8.
REQ-037 ch2 COUNT=0, W=4, GAP=4 -> continuous 8-cycle period; abort mid-ACTIVE -> idle level next cycle, no done.
REQ-038 Rewrite WIDTH during a busy sequence and retrigger mid-run -> current sequence unchanged and retrigger ignored; with PULSEGEN_RETRIG_EN, restart at DELAY using the new WIDTH.
REQ-039 Simultaneous trig+abort, WIDTH=0 trigger, cfgCh=NUM_CH write, and io_rst_n low mid-pulse -> all match REQ-024/026/008/030.
